// File: rtl/rng_hist_stats_pkg.sv
// Shared sizes, opcodes and state encoding for the RNG histogram statistics block.
package rng_stats_pkg;

  localparam int NUM_BINS  = 64;
  localparam int NUM_WORDS = 66;
  localparam int BIN_BITS  = 6;

  localparam logic [3:0] OP_START = 4'd1;
  localparam logic [3:0] OP_STOP  = 4'd2;
  localparam logic [3:0] OP_CLEAR = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rng_hist_stats_if.sv
// Command, sample handshake and register-file bundle between the Avalon slave side
// (master modport) and the statistics engine (slave modport).
interface rng_hist_stats_if;
  import rng_stats_pkg::*;

  logic [63:0] cmd;
  logic        sample_valid;
  logic [63:0] sample_data;
  logic        sample_ready;
  logic [63:0] stats [NUM_WORDS];
  logic        done;

  modport master (
    output cmd, sample_valid, sample_data,
    input  sample_ready, stats, done
  );

  modport slave (
    input  cmd, sample_valid, sample_data,
    output sample_ready, stats, done
  );

endinterface

// File: rtl/rng_hist_stats_popcount64.sv
// Combinational 64-bit population count, used only when RNG_MONOBIT_EN is defined.
module rng_popcount64 (
  input  logic [63:0] i_data,
  output logic [6:0]  o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < 64; i++) begin
      o_count = o_count + 7'(i_data[i]);
    end
  end

endmodule

// File: rtl/rng_hist_stats.sv
// Histogram of the top 6 bits of accepted random samples, plus a total and status word.
// Define RNG_MONOBIT_EN to add a 48-bit monobit (popcount) accumulator in stats[65][63:16].
module rng_hist_stats
  import rng_stats_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  rng_hist_stats_if.slave bus
);

  state_t      r_state;
  logic [31:0] r_targetN;
  logic [31:0] r_accepted;
  logic        r_done;
  logic        r_s1Valid;
  logic [BIN_BITS-1:0] r_s1Bin;
  logic [63:0] r_bins [NUM_BINS];
  logic [63:0] r_total;
  logic [47:0] w_monoField;

  logic [3:0] w_opcode;
  logic       w_cmdPresent;
  logic       w_start;
  logic       w_stop;
  logic       w_clear;
  logic       w_ready;
  logic       w_handshake;
  logic       w_lastSample;

  assign w_opcode     = bus.cmd[3:0];
  assign w_cmdPresent = |bus.cmd;
  assign w_start      = (w_opcode == OP_START);
  assign w_stop       = (w_opcode == OP_STOP);
  assign w_clear      = (w_opcode == OP_CLEAR);
  assign w_ready      = (r_state == ST_RUN) && !w_cmdPresent &&
                        ((r_targetN == 32'd0) || (r_accepted < r_targetN));
  assign w_handshake  = w_ready && bus.sample_valid;
  assign w_lastSample = w_handshake && (r_targetN != 32'd0) &&
                        ((r_accepted + 32'd1) == r_targetN);

`ifdef RNG_MONOBIT_EN
  logic [6:0]  w_pop;
  logic [6:0]  r_s1Pop;
  logic [47:0] r_monoCount;

  rng_popcount64 u_popcount (
    .i_data  (bus.sample_data),
    .o_count (w_pop)
  );

  assign w_monoField = r_monoCount;
`else
  assign w_monoField = '0;
`endif

  // START/CLEAR share the counter wipe with reset and also discard the stage-1 sample.
  always_ff @(posedge clk) begin
    if (reset || w_start || w_clear) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        r_bins[i] <= '0;
      end
      r_total    <= '0;
      r_accepted <= '0;
      r_s1Valid  <= 1'b0;
      r_s1Bin    <= '0;
      r_done     <= 1'b0;
`ifdef RNG_MONOBIT_EN
      r_s1Pop     <= '0;
      r_monoCount <= '0;
`endif
      if (reset) begin
        r_state   <= ST_IDLE;
        r_targetN <= '0;
      end else if (w_start) begin
        r_state   <= ST_RUN;
        r_targetN <= bus.cmd[63:32];
      end else begin
        r_state   <= ST_IDLE;
      end
    end else begin
      if (r_s1Valid) begin
        r_bins[r_s1Bin] <= r_bins[r_s1Bin] + 64'd1;
        r_total         <= r_total + 64'd1;
`ifdef RNG_MONOBIT_EN
        r_monoCount     <= r_monoCount + 48'(r_s1Pop);
`endif
      end
      r_s1Valid <= w_handshake;
      if (w_handshake) begin
        r_s1Bin    <= bus.sample_data[63:64-BIN_BITS];
        r_accepted <= r_accepted + 32'd1;
`ifdef RNG_MONOBIT_EN
        r_s1Pop    <= w_pop;
`endif
      end
      // DRAIN waits for the last sample to commit; a free run (N==0) returns to IDLE.
      case (r_state)
        ST_RUN: begin
          if (w_stop || w_lastSample) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!r_s1Valid) begin
            r_state <= (r_targetN != 32'd0) ? ST_DONE : ST_IDLE;
            r_done  <= (r_targetN != 32'd0);
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BINS; i++) begin
      bus.stats[i] = r_bins[i];
    end
    bus.stats[NUM_BINS]     = r_total;
    bus.stats[NUM_BINS + 1] = {w_monoField, 13'd0, r_done, r_state};
  end

  assign bus.sample_ready = w_ready;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_rng_hist_stats.sv
// Directed self-checking bench for rng_hist_stats; expected values are hand-computed.
// Honours RNG_MONOBIT_EN for the monobit field expectation.
module tb_rng_hist_stats;
  import rng_stats_pkg::*;

  logic clk;
  logic reset;
  int   totalChecks;
  int   badChecks;

  rng_hist_stats_if bus ();

  rng_hist_stats dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] cmdWord(logic [31:0] n, logic [3:0] op);
    return {n, 28'd0, op};
  endfunction

  function automatic logic [63:0] binSample(int b);
    logic [5:0] bin6;
    bin6 = 6'(b);
    return {bin6, 58'd0};
  endfunction

  function automatic logic [63:0] statusWord(logic [1:0] st, logic dn, logic [47:0] mono);
    return {mono, 13'd0, dn, st};
  endfunction

  task automatic applyStimulus(logic [63:0] c, logic v, logic [63:0] d);
    bus.cmd          = c;
    bus.sample_valid = v;
    bus.sample_data  = d;
  endtask

  task automatic checkOutput(string tag, logic [63:0] actual, logic [63:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Moves to 2 time units after the next rising edge: registers settled, inputs free to change.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    reset       = 1'b1;
    applyStimulus(64'd0, 1'b0, 64'd0);
    tick();
    tick();
    #1;
    checkOutput("reset_status", bus.stats[65], 64'd0);
    checkOutput("reset_bin0", bus.stats[0], 64'd0);
    checkOutput("reset_total", bus.stats[64], 64'd0);
    checkOutput("reset_ready", 64'(bus.sample_ready), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    reset = 1'b0;

    // Basic count: N=4, four back-to-back samples
    applyStimulus(cmdWord(32'd4, OP_START), 1'b0, 64'd0);
    tick();
    applyStimulus(64'd0, 1'b1, 64'h0000_0000_0000_0000);
    #1;
    checkOutput("basic_run_state", bus.stats[65], statusWord(2'd1, 1'b0, 48'd0));
    checkOutput("basic_ready0", 64'(bus.sample_ready), 64'd1);
    tick();
    applyStimulus(64'd0, 1'b1, 64'hFC00_0000_0000_0000);
    #1;
    checkOutput("basic_total_c1", bus.stats[64], 64'd0);
    tick();
    applyStimulus(64'd0, 1'b1, 64'hFC00_0000_0000_0000);
    #1;
    checkOutput("basic_total_c2", bus.stats[64], 64'd1);
    checkOutput("basic_bin0_c2", bus.stats[0], 64'd1);
    tick();
    applyStimulus(64'd0, 1'b1, 64'h0400_0000_0000_0000);
    #1;
    checkOutput("basic_ready3", 64'(bus.sample_ready), 64'd1);
    tick();
    applyStimulus(64'd0, 1'b1, 64'h0800_0000_0000_0000);
    #1;
    checkOutput("basic_ready_after4", 64'(bus.sample_ready), 64'd0);
    checkOutput("basic_done_c4", 64'(bus.done), 64'd0);
    tick();
    applyStimulus(64'd0, 1'b0, 64'd0);
    #1;
    checkOutput("basic_done_c5", 64'(bus.done), 64'd0);
    tick();
    #1;
    checkOutput("basic_done_c6", 64'(bus.done), 64'd1);
    checkOutput("basic_status", bus.stats[65], statusWord(2'd3, 1'b1, 48'd0));
    checkOutput("basic_bin0", bus.stats[0], 64'd1);
    checkOutput("basic_bin63", bus.stats[63], 64'd2);
    checkOutput("basic_bin1", bus.stats[1], 64'd1);
    checkOutput("basic_bin2", bus.stats[2], 64'd0);
    checkOutput("basic_total", bus.stats[64], 64'd4);

    // CLEAR from DONE, then an opcode-0 write must change nothing
    applyStimulus(cmdWord(32'd0, OP_CLEAR), 1'b0, 64'd0);
    tick();
    applyStimulus(64'hDEAD_BEEF_0000_0000, 1'b0, 64'd0);
    #1;
    checkOutput("clear_status", bus.stats[65], 64'd0);
    checkOutput("clear_bin63", bus.stats[63], 64'd0);
    tick();
    applyStimulus(64'd0, 1'b0, 64'd0);
    #1;
    checkOutput("ignored_status", bus.stats[65], 64'd0);
    checkOutput("ignored_total", bus.stats[64], 64'd0);

    // Free run with N=0, ten samples to bins 0..9, then STOP with a sample that must be refused
    applyStimulus(cmdWord(32'd0, OP_START), 1'b0, 64'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(64'd0, 1'b1, binSample(i));
      tick();
    end
    applyStimulus(cmdWord(32'd0, OP_STOP), 1'b1, binSample(40));
    #1;
    checkOutput("stop_ready", 64'(bus.sample_ready), 64'd0);
    tick();
    applyStimulus(64'd0, 1'b0, 64'd0);
    #1;
    checkOutput("stop_drain", bus.stats[65], statusWord(2'd2, 1'b0, 48'd0));
    tick();
    #1;
    checkOutput("stop_idle", bus.stats[65], statusWord(2'd0, 1'b0, 48'd0));
    checkOutput("stop_total", bus.stats[64], 64'd10);
    checkOutput("stop_bin9", bus.stats[9], 64'd1);
    checkOutput("stop_bin40", bus.stats[40], 64'd0);
    checkOutput("stop_done", 64'(bus.done), 64'd0);

    // CLEAR on the cycle after a handshake discards the in-flight sample
    applyStimulus(cmdWord(32'd0, OP_START), 1'b0, 64'd0);
    tick();
    applyStimulus(64'd0, 1'b1, binSample(7));
    tick();
    applyStimulus(cmdWord(32'd0, OP_CLEAR), 1'b0, 64'd0);
    tick();
    applyStimulus(64'd0, 1'b0, 64'd0);
    tick();
    #1;
    checkOutput("collide_status", bus.stats[65], 64'd0);
    checkOutput("collide_bin7", bus.stats[7], 64'd0);
    checkOutput("collide_total", bus.stats[64], 64'd0);

    // Reset during RUN with a sample in stage 1
    applyStimulus(cmdWord(32'd0, OP_START), 1'b0, 64'd0);
    tick();
    applyStimulus(64'd0, 1'b1, binSample(3));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("midreset_ready", 64'(bus.sample_ready), 64'd0);
    checkOutput("midreset_done", 64'(bus.done), 64'd0);
    checkOutput("midreset_status", bus.stats[65], 64'd0);
    checkOutput("midreset_bin3", bus.stats[3], 64'd0);
    checkOutput("midreset_total", bus.stats[64], 64'd0);
    applyStimulus(64'd0, 1'b0, 64'd0);

    // Monobit: all-ones plus 0x1 gives 65 set bits
    applyStimulus(cmdWord(32'd2, OP_START), 1'b0, 64'd0);
    tick();
    applyStimulus(64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    applyStimulus(64'd0, 1'b1, 64'h0000_0000_0000_0001);
    tick();
    applyStimulus(64'd0, 1'b0, 64'd0);
    tick();
    tick();
    #1;
`ifdef RNG_MONOBIT_EN
    checkOutput("mono_status", bus.stats[65], statusWord(2'd3, 1'b1, 48'd65));
`else
    checkOutput("mono_status", bus.stats[65], statusWord(2'd3, 1'b1, 48'd0));
`endif
    checkOutput("mono_bin63", bus.stats[63], 64'd1);
    checkOutput("mono_bin0", bus.stats[0], 64'd1);
    checkOutput("mono_total", bus.stats[64], 64'd2);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
